// File: rtl/stage_ma_pkg.sv
// Shared pipeline types for the memory-access stage.
//   ex_ma_reg_t : EX-MA pipeline register consumed by stage_ma
//   ma_wb_reg_t : MA-WB pipeline register produced by stage_ma
//   ma_state_t  : memory transaction FSM states
//   SIZE_*      : dmem_size encodings
//   WB_SEL_*    : reg_wr_sel encodings (writeback source select)
package stage_ma_pkg;

    localparam logic [1:0] SIZE_B = 2'b00;
    localparam logic [1:0] SIZE_H = 2'b01;
    localparam logic [1:0] SIZE_W = 2'b10;

    localparam logic [1:0] WB_SEL_ALU = 2'b00;
    localparam logic [1:0] WB_SEL_MEM = 2'b01;
    localparam logic [1:0] WB_SEL_PC4 = 2'b10;

    typedef enum logic [1:0] {
        MA_IDLE = 2'b00,
        MA_REQ  = 2'b01,
        MA_RSP  = 2'b10
    } ma_state_t;

    typedef struct packed {
        logic        instr_valid;
        logic [31:0] pc_plus_four;
        logic [31:0] alu_result;
        logic [31:0] dmem_data;
        logic        dmem_wr_en;
        logic        dmem_rd_en;
        logic [1:0]  dmem_size;
        logic        dmem_sign;     // 0 = sign-extend (LB/LH), 1 = zero-extend (LBU/LHU)
        logic        reg_wr_en;
        logic [1:0]  reg_wr_sel;
        logic [4:0]  reg_wr_addr;
    } ex_ma_reg_t;

    typedef struct packed {
        logic        instr_valid;
        logic [31:0] pc_plus_four;
        logic [31:0] alu_result;
        logic [31:0] load_data;
        logic        reg_wr_en;
        logic [1:0]  reg_wr_sel;
        logic [4:0]  reg_wr_addr;
    } ma_wb_reg_t;

endpackage

// File: rtl/stage_ma_lsu_align.sv
// Combinational load/store lane logic.
//   addr_lo    in  2  low address bits
//   size       in  2  SIZE_B / SIZE_H / SIZE_W
//   sign       in  1  0 = sign-extend loads, 1 = zero-extend
//   store_data in  32 store operand
//   rdata      in  32 raw load response word
//   be         out 4  byte enables
//   wdata      out 32 lane-replicated store data
//   misalign   out 1  access violates natural alignment
//   load_data  out 32 aligned and extended load result
module lsu_align
    import stage_ma_pkg::*;
(
    input  logic [1:0]  addr_lo,
    input  logic [1:0]  size,
    input  logic        sign,
    input  logic [31:0] store_data,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] wdata,
    output logic        misalign,
    output logic [31:0] load_data
);

    logic [31:0] sh;

    assign sh = rdata >> {addr_lo, 3'b000};

    always_comb begin
        be        = 4'b1111;
        wdata     = store_data;
        misalign  = 1'b0;
        load_data = sh;
        case (size)
            SIZE_B: begin
                be        = 4'b0001 << addr_lo;
                wdata     = {4{store_data[7:0]}};
                load_data = sign ? {24'b0, sh[7:0]} : {{24{sh[7]}}, sh[7:0]};
            end
            SIZE_H: begin
                be        = 4'b0011 << {addr_lo[1], 1'b0};
                wdata     = {2{store_data[15:0]}};
                misalign  = addr_lo[0];
                load_data = sign ? {16'b0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
            end
            default: begin
                misalign  = |addr_lo;
            end
        endcase
    end

endmodule

// File: rtl/stage_ma.sv
// Memory-access stage: issues loads/stores over a req/gnt/rvalid bus,
// stalls the front of the pipeline while a transaction is open, and
// produces the MA-WB pipeline register.
//   clk, rst_i              clock, synchronous active-high reset
//   ex_ma_i                 EX-MA register (held stable by upstream while stall_o=1)
//   squash_i                kill the instruction currently in MA
//   stall_i                 downstream stall, MA-WB holds
//   dmem_req_o/we/addr/wdata/be, dmem_gnt_i    request channel
//   dmem_rvalid_i, dmem_rdata_i                response channel
//   stall_o                 MA busy
//   misalign_o, bus_err_o   error pulses
//   ma_wb_reg_o             MA-WB register
module stage_ma
    import stage_ma_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
)(
    input  logic        clk,
    input  logic        rst_i,
    input  ex_ma_reg_t  ex_ma_i,
    input  logic        squash_i,
    input  logic        stall_i,
    output logic        dmem_req_o,
    output logic        dmem_we_o,
    output logic [31:0] dmem_addr_o,
    output logic [31:0] dmem_wdata_o,
    output logic [3:0]  dmem_be_o,
    input  logic        dmem_gnt_i,
    input  logic        dmem_rvalid_i,
    input  logic [31:0] dmem_rdata_i,
    output logic        stall_o,
    output logic        misalign_o,
    output logic        bus_err_o,
    output ma_wb_reg_t  ma_wb_reg_o
);

    localparam int unsigned CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] TO_LAST = CW'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

    ma_state_t   state_q, state_d;
    logic [CW-1:0] cnt_q;
    ex_ma_reg_t  txn_q, cur;
    logic        squashed_q;
    ma_wb_reg_t  ma_wb_q, buf_q, wb_d;
    logic        buf_valid_q;

    logic        is_mem, mem_op, mis_acc, timeout, done;
    logic        req, stall, bus_err, mis_pulse;
    logic [3:0]  al_be;
    logic [31:0] al_wdata, al_load_data;
    logic        al_misalign;

    // In IDLE the request is built straight from EX-MA; afterwards from the
    // copy taken at issue so it stays stable whatever upstream does.
    assign cur = (state_q == MA_IDLE) ? ex_ma_i : txn_q;

    lsu_align u_align (
        .addr_lo    (cur.alu_result[1:0]),
        .size       (cur.dmem_size),
        .sign       (cur.dmem_sign),
        .store_data (cur.dmem_data),
        .rdata      (dmem_rdata_i),
        .be         (al_be),
        .wdata      (al_wdata),
        .misalign   (al_misalign),
        .load_data  (al_load_data)
    );

    // A buffered result belongs to the instruction still sitting in EX-MA
    // under stall_i, so it must not be issued a second time.
    assign is_mem  = cur.instr_valid & (cur.dmem_rd_en | cur.dmem_wr_en)
                   & ~squash_i & ~buf_valid_q;
    assign mem_op  = (state_q == MA_IDLE) & is_mem & ~al_misalign;
    assign mis_acc = (state_q == MA_IDLE) & is_mem &  al_misalign;
    assign timeout = (TIMEOUT_CYCLES != 0) && (state_q != MA_IDLE) && (cnt_q == TO_LAST);

    // State register
    always_ff @(posedge clk) begin
        if (rst_i) begin
            state_q <= MA_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            MA_IDLE: begin
                if (mem_op) begin
                    if (!dmem_gnt_i)          state_d = MA_REQ;
                    else if (!cur.dmem_wr_en) state_d = MA_RSP;
                end
            end
            MA_REQ: begin
                if (squash_i)             state_d = MA_IDLE;
                else if (dmem_gnt_i)      state_d = cur.dmem_wr_en ? MA_IDLE : MA_RSP;
                else if (timeout)         state_d = MA_IDLE;
            end
            MA_RSP: begin
                if (dmem_rvalid_i || timeout) state_d = MA_IDLE;
            end
            default: state_d = MA_IDLE;
        endcase
    end

    // Output logic; wb_d defaults to a bubble carrying the current fields
    always_comb begin
        req       = 1'b0;
        stall     = 1'b0;
        bus_err   = 1'b0;
        mis_pulse = 1'b0;
        done      = 1'b0;
        wb_d.instr_valid  = 1'b0;
        wb_d.pc_plus_four = cur.pc_plus_four;
        wb_d.alu_result   = cur.alu_result;
        wb_d.load_data    = al_load_data;
        wb_d.reg_wr_en    = 1'b0;
        wb_d.reg_wr_sel   = cur.reg_wr_sel;
        wb_d.reg_wr_addr  = cur.reg_wr_addr;
        unique case (state_q)
            MA_IDLE: begin
                wb_d.instr_valid = cur.instr_valid & ~squash_i;
                wb_d.reg_wr_en   = cur.reg_wr_en & ~squash_i & ~mis_acc;
                mis_pulse        = mis_acc;
                if (mem_op) begin
                    req = 1'b1;
                    if (dmem_gnt_i && cur.dmem_wr_en) begin
                        done = 1'b1;
                    end else begin
                        stall            = 1'b1;
                        wb_d.instr_valid = 1'b0;
                        wb_d.reg_wr_en   = 1'b0;
                    end
                end
            end
            MA_REQ: begin
                if (squash_i) begin
                    done = 1'b1;
                end else begin
                    req = 1'b1;
                    if (dmem_gnt_i && cur.dmem_wr_en) begin
                        done             = 1'b1;
                        wb_d.instr_valid = cur.instr_valid;
                        wb_d.reg_wr_en   = cur.reg_wr_en;
                    end else if (!dmem_gnt_i && timeout) begin
                        bus_err          = 1'b1;
                        done             = 1'b1;
                        wb_d.instr_valid = cur.instr_valid;
                    end else begin
                        stall = 1'b1;
                    end
                end
            end
            MA_RSP: begin
                if (dmem_rvalid_i) begin
                    done             = 1'b1;
                    wb_d.instr_valid = cur.instr_valid & ~(squashed_q | squash_i);
                    wb_d.reg_wr_en   = cur.reg_wr_en   & ~(squashed_q | squash_i);
                end else if (timeout) begin
                    bus_err          = 1'b1;
                    done             = 1'b1;
                    wb_d.instr_valid = cur.instr_valid & ~(squashed_q | squash_i);
                end else begin
                    stall = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst_i || state_d != state_q || state_q == MA_IDLE) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_op) begin
            txn_q <= ex_ma_i;
        end
        squashed_q <= ~rst_i & (state_q == MA_RSP) & (squashed_q | squash_i);
    end

    // Under stall_i a finished transaction parks in buf_q; the FSM is free
    // to return to IDLE while MA-WB keeps its old contents.
    always_ff @(posedge clk) begin
        if (rst_i) begin
            ma_wb_q     <= '0;
            buf_q       <= '0;
            buf_valid_q <= 1'b0;
        end else if (stall_i) begin
            if (done) begin
                buf_q       <= wb_d;
                buf_valid_q <= 1'b1;
            end
        end else if (buf_valid_q) begin
            ma_wb_q     <= buf_q;
            buf_valid_q <= 1'b0;
        end else begin
            ma_wb_q <= wb_d;
        end
    end

    assign dmem_req_o   = req & ~rst_i;
    assign dmem_we_o    = cur.dmem_wr_en;
    assign dmem_addr_o  = {cur.alu_result[31:2], 2'b00};
    assign dmem_wdata_o = al_wdata;
    assign dmem_be_o    = al_be;
    assign stall_o      = stall & ~rst_i;
    assign misalign_o   = mis_pulse & ~rst_i;
    assign bus_err_o    = bus_err & ~rst_i;
    assign ma_wb_reg_o  = ma_wb_q;

endmodule

// File: tb/tb_stage_ma.sv
module tb_stage_ma;
    import stage_ma_pkg::*;

    localparam int T = 4;

    logic        clk = 1'b0;
    logic        rst_i;
    ex_ma_reg_t  ex_ma;
    logic        squash, stall_in;
    logic        dmem_req, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata;
    logic [3:0]  dmem_be;
    logic        gnt, rvalid;
    logic [31:0] rdata;
    logic        stall_out, misalign, bus_err;
    ma_wb_reg_t  ma_wb;

    int checks = 0;
    int errors = 0;

    int          seen_stall;
    logic [3:0]  seen_be;
    logic [31:0] seen_wdata, seen_addr, seen_load;
    logic        seen_mis, seen_berr, seen_req;

    always #5 clk = ~clk;

    stage_ma #(.TIMEOUT_CYCLES(T)) dut (
        .clk           (clk),
        .rst_i         (rst_i),
        .ex_ma_i       (ex_ma),
        .squash_i      (squash),
        .stall_i       (stall_in),
        .dmem_req_o    (dmem_req),
        .dmem_we_o     (dmem_we),
        .dmem_addr_o   (dmem_addr),
        .dmem_wdata_o  (dmem_wdata),
        .dmem_be_o     (dmem_be),
        .dmem_gnt_i    (gnt),
        .dmem_rvalid_i (rvalid),
        .dmem_rdata_i  (rdata),
        .stall_o       (stall_out),
        .misalign_o    (misalign),
        .bus_err_o     (bus_err),
        .ma_wb_reg_o   (ma_wb)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int nbytes(input logic [1:0] size);
        return (size == SIZE_B) ? 1 : (size == SIZE_H) ? 2 : 4;
    endfunction

    // Lanes covered by a naturally aligned container of the access size
    function automatic logic [3:0] ref_be(input int off, input logic [1:0] size);
        int n, base;
        logic [3:0] be;
        n = nbytes(size);
        base = off - (off % n);
        be = '0;
        for (int l = 0; l < 4; l++) be[l] = (l >= base) && (l < base + n);
        return be;
    endfunction

    function automatic logic [31:0] ref_wdata(input logic [31:0] d, input logic [1:0] size);
        if (nbytes(size) == 1) return {24'b0, d[7:0]} * 32'h0101_0101;
        if (nbytes(size) == 2) return {16'b0, d[15:0]} * 32'h0001_0001;
        return d;
    endfunction

    function automatic logic [31:0] ref_load(input logic [31:0] w, input int off,
                                             input logic [1:0] size, input logic usign);
        logic [31:0] mask, v;
        if (nbytes(size) == 4) return w;
        mask = (nbytes(size) == 1) ? 32'hFF : 32'hFFFF;
        v = (w >> (8 * off)) & mask;
        if (!usign && v > (mask >> 1)) v = v | ~mask;
        return v;
    endfunction

    function automatic ex_ma_reg_t mk_op(input int kind, input logic [31:0] addr,
                                         input logic [1:0] size, input logic usign,
                                         input logic [31:0] data);
        ex_ma_reg_t i;
        i = '0;
        i.instr_valid  = 1'b1;
        i.pc_plus_four = $urandom;
        i.alu_result   = addr;
        i.dmem_data    = data;
        i.dmem_size    = size;
        i.dmem_sign    = usign;
        i.dmem_rd_en   = (kind == 1);
        i.dmem_wr_en   = (kind == 2);
        i.reg_wr_en    = (kind != 2);
        i.reg_wr_sel   = (kind == 1) ? WB_SEL_MEM : WB_SEL_ALU;
        i.reg_wr_addr  = 5'($urandom_range(1, 31));
        return i;
    endfunction

    // Present one instruction; memory grants g cycles after the first request
    // cycle and responds r cycles after the grant. Transaction-level model:
    // each wait for gnt or rvalid is abandoned after T cycles in that phase.
    task automatic run_instr(input ex_ma_reg_t ins, input int g, input int r,
                             input logic [31:0] word, input string tag);
        bit mem, mis, ld, tmo;
        int off, e, req_last;
        off = int'(ins.alu_result % 4);
        mem = ins.instr_valid && (ins.dmem_rd_en || ins.dmem_wr_en);
        mis = mem && (off % nbytes(ins.dmem_size) != 0);
        ld  = mem && !mis && !ins.dmem_wr_en;
        tmo = 0;
        if (!mem || mis)            begin e = 0;     req_last = -1; end
        else if (g > T)             begin e = T;     req_last = T; tmo = 1; end
        else if (ins.dmem_wr_en)    begin e = g;     req_last = g; end
        else if (r > T)             begin e = g + T; req_last = g; tmo = 1; end
        else                        begin e = g + r; req_last = g; end
        seen_stall = 0; seen_mis = 0; seen_berr = 0; seen_req = 0;
        for (int c = 0; c <= e; c++) begin
            @(negedge clk);
            ex_ma  = ins;
            gnt    = (c == g);
            rvalid = ld && (c == g + r);
            rdata  = word;
            #1;
            if (stall_out === 1'b1) seen_stall++;
            seen_mis  |= misalign;
            seen_berr |= bus_err;
            seen_req  |= dmem_req;
            chk({tag, ":req"},   dmem_req,  c <= req_last);
            chk({tag, ":stall"}, stall_out, c < e);
            chk({tag, ":berr"},  bus_err,   tmo && c == e);
            chk({tag, ":mis"},   misalign,  mis);
            if (c <= req_last) begin
                seen_be = dmem_be; seen_wdata = dmem_wdata; seen_addr = dmem_addr;
                chk({tag, ":addr"}, dmem_addr, ins.alu_result - off);
                chk({tag, ":we"},   dmem_we,   ins.dmem_wr_en);
                chk({tag, ":be"},   dmem_be,   ref_be(off, ins.dmem_size));
                if (ins.dmem_wr_en)
                    chk({tag, ":wdata"}, dmem_wdata, ref_wdata(ins.dmem_data, ins.dmem_size));
            end
            @(posedge clk); #1;
            if (c < e) begin
                chk({tag, ":bubble"}, ma_wb.instr_valid, 1'b0);
            end else begin
                chk({tag, ":wb_valid"}, ma_wb.instr_valid, ins.instr_valid);
                chk({tag, ":wb_pc4"},   ma_wb.pc_plus_four, ins.pc_plus_four);
                chk({tag, ":wb_alu"},   ma_wb.alu_result, ins.alu_result);
                chk({tag, ":wb_wen"},   ma_wb.reg_wr_en, ins.reg_wr_en && !mis && !tmo);
                chk({tag, ":wb_sel"},   ma_wb.reg_wr_sel, ins.reg_wr_sel);
                chk({tag, ":wb_rd"},    ma_wb.reg_wr_addr, ins.reg_wr_addr);
                seen_load = ma_wb.load_data;
                if (ld && !tmo)
                    chk({tag, ":wb_load"}, ma_wb.load_data,
                        ref_load(word, off, ins.dmem_size, ins.dmem_sign));
            end
        end
        gnt = 1'b0; rvalid = 1'b0;
    endtask

    initial begin
        ex_ma_reg_t ins, alu;
        rst_i = 1'b1; ex_ma = '0; squash = 0; stall_in = 0;
        gnt = 0; rvalid = 0; rdata = '0;
        @(posedge clk); @(posedge clk); #1;
        chk("rst_valid",  ma_wb.instr_valid, 1'b0);
        chk("rst_req",    dmem_req, 1'b0);
        chk("rst_stall",  stall_out, 1'b0);
        chk("rst_mis",    misalign, 1'b0);
        chk("rst_berr",   bus_err, 1'b0);
        @(negedge clk); rst_i = 1'b0;

        alu = mk_op(0, 32'h1234, SIZE_W, 0, 0);
        run_instr(alu, 0, 1, 0, "alu");
        chk("alu_result", ma_wb.alu_result, 32'h1234);
        chk("alu_noreq",  seen_req, 1'b0);

        run_instr(mk_op(2, 32'h1003, SIZE_B, 0, 32'hAB), 0, 1, 0, "sb");
        chk("sb_be",    seen_be, 4'b1000);
        chk("sb_wdata", seen_wdata, 32'hABAB_ABAB);
        chk("sb_addr",  seen_addr, 32'h1000);
        chk("sb_stall", seen_stall, 0);

        run_instr(mk_op(1, 32'h2001, SIZE_B, 0, 0), 2, 3, 32'h0000_8000, "lb");
        chk("lb_stall", seen_stall, 5);
        chk("lb_data",  seen_load, 32'hFFFF_FF80);
        run_instr(mk_op(1, 32'h2001, SIZE_B, 1, 0), 2, 3, 32'h0000_8000, "lbu");
        chk("lbu_data", seen_load, 32'h0000_0080);

        run_instr(mk_op(1, 32'h2002, SIZE_W, 0, 0), 0, 1, 0, "lw_mis");
        chk("lw_mis_pulse", seen_mis, 1'b1);
        chk("lw_mis_noreq", seen_req, 1'b0);
        chk("lw_mis_wen",   ma_wb.reg_wr_en, 1'b0);

        // squash after grant: response consumed, result invalid
        ins = mk_op(1, 32'h4002, SIZE_H, 0, 0);
        @(negedge clk); ex_ma = ins; gnt = 1;
        @(negedge clk); gnt = 0; squash = 1; #1;
        chk("sq_rsp_stall", stall_out, 1'b1);
        @(negedge clk); squash = 0; rvalid = 1; rdata = 32'h1234_5678; #1;
        chk("sq_rsp_stall_drop", stall_out, 1'b0);
        @(posedge clk); #1;
        chk("sq_rsp_valid", ma_wb.instr_valid, 1'b0);
        chk("sq_rsp_wen",   ma_wb.reg_wr_en, 1'b0);
        @(negedge clk); rvalid = 0; ex_ma = '0;

        // squash while waiting for grant drops the request
        @(negedge clk); ex_ma = mk_op(1, 32'h4100, SIZE_W, 0, 0); #1;
        chk("sq_req_req0", dmem_req, 1'b1);
        @(negedge clk); squash = 1; #1;
        chk("sq_req_drop",  dmem_req, 1'b0);
        chk("sq_req_stall", stall_out, 1'b0);
        @(posedge clk); #1;
        chk("sq_req_valid", ma_wb.instr_valid, 1'b0);
        @(negedge clk); squash = 0; ex_ma = '0;

        // reset during RSP, late rvalid afterwards is ignored
        @(negedge clk); ex_ma = mk_op(1, 32'h3000, SIZE_W, 0, 0); gnt = 1;
        @(negedge clk); gnt = 0; rst_i = 1;
        @(negedge clk); rst_i = 0; ex_ma = '0; rvalid = 1; rdata = 32'hDEAD_BEEF; #1;
        chk("rst_rsp_stall", stall_out, 1'b0);
        chk("rst_rsp_req",   dmem_req, 1'b0);
        @(posedge clk); #1;
        chk("rst_rsp_valid", ma_wb.instr_valid, 1'b0);
        @(negedge clk); rvalid = 0;
        run_instr(mk_op(0, 32'h3333, SIZE_W, 0, 0), 0, 1, 0, "post_rst");

        // grant never comes
        run_instr(mk_op(2, 32'h6000, SIZE_W, 0, 32'h55), 100, 1, 0, "tmo");
        chk("tmo_berr",  seen_berr, 1'b1);
        chk("tmo_stall", seen_stall, T);
        run_instr(mk_op(0, 32'h6004, SIZE_W, 0, 0), 0, 1, 0, "post_tmo");

        // load completes under stall_i: MA-WB holds, result parked, no reissue
        run_instr(mk_op(0, 32'hCAFE_0000, SIZE_W, 0, 0), 0, 1, 0, "pre_hold");
        ins = mk_op(1, 32'h5003, SIZE_B, 1, 0);
        @(negedge clk); ex_ma = ins; stall_in = 1; gnt = 1; #1;
        chk("hold_req", dmem_req, 1'b1);
        @(posedge clk); #1;
        chk("hold_wb0", ma_wb.alu_result, 32'hCAFE_0000);
        @(negedge clk); gnt = 0; rvalid = 1; rdata = 32'h7F00_0000; #1;
        chk("hold_stall", stall_out, 1'b0);
        @(posedge clk); #1;
        chk("hold_wb1", ma_wb.alu_result, 32'hCAFE_0000);
        @(negedge clk); rvalid = 0; #1;
        chk("hold_noreissue", dmem_req, 1'b0);
        @(negedge clk); stall_in = 0; #1;
        chk("hold_noreissue2", dmem_req, 1'b0);
        @(posedge clk); #1;
        chk("hold_wb_alu",  ma_wb.alu_result, 32'h5003);
        chk("hold_wb_load", ma_wb.load_data, 32'h0000_007F);
        chk("hold_wb_vld",  ma_wb.instr_valid, 1'b1);
        @(negedge clk); ex_ma = '0;

        for (int n = 0; n < 40; n++) begin
            ins = mk_op($urandom_range(0, 2), $urandom, 2'($urandom_range(0, 2)),
                        1'($urandom_range(0, 1)), $urandom);
            if ($urandom_range(0, 7) == 0) ins.instr_valid = 1'b0;
            run_instr(ins, $urandom_range(0, 5), $urandom_range(1, 5), $urandom, "rnd");
        end

        @(negedge clk); ex_ma = '0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
